alu_issue: RTL and testbench

Execute-stage issue unit that drives the ALU operand and control inputs and captures its result and zero flag. It decodes RV32I R-type, I-type ALU and BEQ/BNE instructions into the 4-bit ALU control code. It applies operand fix-ups: shift-amount masking and a signed-compare bias. It is a two-register valid/ready pipeline (issue register, then result register) between decode and memory/writeback.

---
 rtl/alu_issue.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_issue.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: execute-stage issue unit. Decodes RV32I R-type, I-type ALU and
// BEQ/BNE into a 4-bit ALU code, applies operand fix-ups (shift-amount mask,
// signed-compare bias) and holds them in an issue register that drives the
// external ALU; the ALU result and zero flag are captured in a result register.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready              decode-side handshake
//   opcode, funct3, funct7         instruction fields
//   rs1_data, rs2_data, imm, rd    operands, sign-extended immediate, dest reg
//   alu_in1, alu_in2, alu_control  registered ALU drive
//   alu_result, zero_flag          combinational ALU response
//   out_valid/out_ready            writeback-side handshake
//   out_result, out_rd, out_taken, out_illegal  captured result entry
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        zero_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_taken,
    output logic        out_illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    // issue register
    logic        i_valid_q, i_valid_d;
    logic [3:0]  i_ctrl_q, i_ctrl_d;
    logic [31:0] i_in1_q, i_in1_d;
    logic [31:0] i_in2_q, i_in2_d;
    logic [4:0]  i_rd_q, i_rd_d;
    logic        i_beq_q, i_beq_d;
    logic        i_bne_q, i_bne_d;
    logic        i_ill_q, i_ill_d;

    // result register
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_taken_q, out_taken_d;
    logic        out_illegal_q, out_illegal_d;

    logic        i_adv;
    logic        accept;

    // decoder outputs
    logic [3:0]  dec_ctrl;
    logic        dec_shift;
    logic        dec_slt;
    logic        dec_bad;
    logic        dec_ill;
    logic        dec_beq;
    logic        dec_bne;
    logic        dec_use_imm;
    logic        dec_branch;
    logic [31:0] dec_in1;
    logic [31:0] dec_in2;
    logic [4:0]  dec_rd;

    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_shift   = 1'b0;
        dec_slt     = 1'b0;
        dec_bad     = 1'b0;
        dec_ill     = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_use_imm = 1'b0;
        dec_branch  = 1'b0;

        // funct3 map shared by R-type and I-type
        case (funct3)
            3'b000: dec_ctrl = ALU_ADD;
            3'b001: begin
                dec_ctrl  = ALU_SLL;
                dec_shift = 1'b1;
            end
            3'b010: begin
                dec_ctrl = ALU_SLT;
                dec_slt  = 1'b1;
            end
            3'b011: dec_bad = 1'b1;
            3'b100: dec_ctrl = ALU_XOR;
            3'b101: begin
                dec_ctrl  = ALU_SRL;
                dec_shift = 1'b1;
            end
            3'b110: dec_ctrl = ALU_OR;
            3'b111: dec_ctrl = ALU_AND;
        endcase

        case (opcode)
            OP_R: begin
                if (funct3 == 3'b000) begin
                    if (funct7 == F7_ALT) dec_ctrl = ALU_SUB;
                    dec_ill = (funct7 != 7'd0) && (funct7 != F7_ALT);
                end else begin
                    dec_ill = dec_bad || (funct7 != 7'd0);
                end
            end
            OP_I: begin
                dec_use_imm = 1'b1;
                // only the shift immediates carry funct7
                dec_ill = dec_bad || (dec_shift && funct7 != 7'd0);
            end
            OP_B: begin
                dec_branch = 1'b1;
                dec_ctrl   = ALU_SUB;
                dec_shift  = 1'b0;
                dec_slt    = 1'b0;
                dec_beq    = (funct3 == 3'b000);
                dec_bne    = (funct3 == 3'b001);
                dec_ill    = (funct3[2:1] != 2'b00);
            end
            default: dec_ill = 1'b1;
        endcase

        dec_in1 = rs1_data;
        dec_in2 = dec_use_imm ? imm : rs2_data;
        if (dec_shift) dec_in2 = dec_in2 & 32'h0000_001F;
        // flip sign bits so the ALU's unsigned compare orders signed values
        if (dec_slt) begin
            dec_in1[31] = ~dec_in1[31];
            dec_in2[31] = ~dec_in2[31];
        end
        dec_rd = dec_branch ? 5'd0 : rd;

        if (dec_ill) begin
            dec_ctrl = ALU_ADD;
            dec_in1  = 32'd0;
            dec_in2  = 32'd0;
            dec_rd   = 5'd0;
            dec_beq  = 1'b0;
            dec_bne  = 1'b0;
        end
    end

    assign i_adv    = i_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !i_valid_q || i_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        i_valid_d = i_valid_q;
        i_ctrl_d  = i_ctrl_q;
        i_in1_d   = i_in1_q;
        i_in2_d   = i_in2_q;
        i_rd_d    = i_rd_q;
        i_beq_d   = i_beq_q;
        i_bne_d   = i_bne_q;
        i_ill_d   = i_ill_q;
        if (accept) begin
            i_valid_d = 1'b1;
            i_ctrl_d  = dec_ctrl;
            i_in1_d   = dec_in1;
            i_in2_d   = dec_in2;
            i_rd_d    = dec_rd;
            i_beq_d   = dec_beq;
            i_bne_d   = dec_bne;
            i_ill_d   = dec_ill;
        end else if (i_adv) begin
            i_valid_d = 1'b0;
        end

        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        if (i_adv) begin
            out_valid_d   = 1'b1;
            out_result_d  = i_ill_q ? 32'd0 : alu_result;
            out_rd_d      = i_rd_q;
            out_taken_d   = (i_beq_q && zero_flag) || (i_bne_q && !zero_flag);
            out_illegal_d = i_ill_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_valid_q     <= 1'b0;
            i_ctrl_q      <= ALU_ADD;
            i_in1_q       <= 32'd0;
            i_in2_q       <= 32'd0;
            i_rd_q        <= 5'd0;
            i_beq_q       <= 1'b0;
            i_bne_q       <= 1'b0;
            i_ill_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 32'd0;
            out_rd_q      <= 5'd0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            i_valid_q     <= i_valid_d;
            i_ctrl_q      <= i_ctrl_d;
            i_in1_q       <= i_in1_d;
            i_in2_q       <= i_in2_d;
            i_rd_q        <= i_rd_d;
            i_beq_q       <= i_beq_d;
            i_bne_q       <= i_bne_d;
            i_ill_q       <= i_ill_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_in1     = i_in1_q;
    assign alu_in2     = i_in2_q;
    assign alu_control = i_ctrl_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_taken   = out_taken_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: random and directed stimulus for alu_issue, with an ALU model
// driving alu_result/zero_flag and an in-order queue of expected entries.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_taken;
    logic        out_illegal;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_result(alu_result), .zero_flag(zero_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_taken(out_taken), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            4'd0: alu_result = alu_in1 & alu_in2;
            4'd1: alu_result = alu_in1 | alu_in2;
            4'd2: alu_result = alu_in1 + alu_in2;
            4'd3: alu_result = alu_in1 - alu_in2;
            4'd4: alu_result = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
            4'd5: alu_result = alu_in1 << alu_in2[4:0];
            4'd6: alu_result = alu_in1 >> alu_in2[4:0];
            4'd7: alu_result = alu_in1 ^ alu_in2;
            default: alu_result = 32'd0;
        endcase
        zero_flag = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        taken;
        logic        ill;
        logic [3:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        int          acc;
    } exp_t;

    exp_t pend[$];
    exp_t prev_exp;
    int   nvec = 0;
    int   nmis = 0;
    int   cyc = 0;
    logic prev_acc = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] sv_in1, sv_in2;
    logic [3:0]  sv_ctrl;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // What the instruction must produce, from the ISA meaning of each op.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] im,
                                   input logic [4:0] r);
        exp_t e;
        logic [31:0] o2;
        logic legal, sub;
        e.taken = 1'b0; e.ill = 1'b0; e.rd = r; e.acc = 0;
        o2 = b; sub = 1'b0; legal = 1'b0;
        e.res = 0; e.ctrl = 4'd2; e.in1 = 0; e.in2 = 0;
        if (op == 7'b0110011) begin
            o2 = b;
            legal = (f3 == 3'd0) ? (f7 == 7'h00 || f7 == 7'h20)
                                 : (f3 != 3'd3 && f7 == 7'h00);
            sub = (f3 == 3'd0) && (f7 == 7'h20);
        end else if (op == 7'b0010011) begin
            o2 = im;
            legal = (f3 != 3'd3) && ((f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00);
        end
        if (op == 7'b1100011) begin
            legal = (f3 < 3'd2);
            e.res = a - b; e.ctrl = 4'd3; e.in1 = a; e.in2 = b; e.rd = 0;
            e.taken = (f3 == 3'd0) ? (a == b) : (a != b);
        end else begin
            e.in1 = a; e.in2 = o2;
            case (f3)
                3'd0: begin
                    e.res = sub ? a - o2 : a + o2;
                    e.ctrl = sub ? 4'd3 : 4'd2;
                end
                3'd1: begin
                    e.res = a << o2[4:0]; e.ctrl = 4'd5; e.in2 = {27'd0, o2[4:0]};
                end
                3'd2: begin
                    e.res = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
                    e.ctrl = 4'd4;
                    e.in1 = a ^ 32'h8000_0000; e.in2 = o2 ^ 32'h8000_0000;
                end
                3'd4: begin e.res = a ^ o2; e.ctrl = 4'd7; end
                3'd5: begin
                    e.res = a >> o2[4:0]; e.ctrl = 4'd6; e.in2 = {27'd0, o2[4:0]};
                end
                3'd6: begin e.res = a | o2; e.ctrl = 4'd1; end
                3'd7: begin e.res = a & o2; e.ctrl = 4'd0; end
                default: ;
            endcase
        end
        if (!legal) begin
            e.res = 0; e.rd = 0; e.taken = 0; e.ill = 1;
            e.ctrl = 4'd2; e.in1 = 0; e.in2 = 0;
        end
        return e;
    endfunction

    // One clock: checks at the falling edge, then returns 1ns after the rise.
    task automatic step();
        exp_t e;
        logic exp_ov;
        @(negedge clk);
        exp_ov = rst_n && pend.size() > 0 && pend[0].acc < cyc;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("in_ready", {31'd0, in_ready},
            {31'd0, (out_ready || pend.size() < 2)});
        if (prev_acc) begin
            chk("alu_control", {28'd0, alu_control}, {28'd0, prev_exp.ctrl});
            chk("alu_in1", alu_in1, prev_exp.in1);
            chk("alu_in2", alu_in2, prev_exp.in2);
        end else if (prev_stall) begin
            chk("stall_in1", alu_in1, sv_in1);
            chk("stall_in2", alu_in2, sv_in2);
            chk("stall_ctrl", {28'd0, alu_control}, {28'd0, sv_ctrl});
        end
        if (exp_ov && out_ready) begin
            e = pend.pop_front();
            chk("out_result", out_result, e.res);
            chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            chk("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        end
        prev_stall = out_valid && !out_ready;
        sv_in1 = alu_in1; sv_in2 = alu_in2; sv_ctrl = alu_control;
        prev_acc = rst_n && in_valid && in_ready;
        if (prev_acc) begin
            prev_exp = model(opcode, funct3, funct7, rs1_data, rs2_data, imm, rd);
            prev_exp.acc = cyc + 1;
            pend.push_back(prev_exp);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] r);
        opcode = op; funct3 = f3; funct7 = f7;
        rs1_data = a; rs2_data = b; imm = im; rd = r;
        in_valid = 1'b1;
    endtask

    task automatic wait_acc();
        int n = 0;
        do begin
            step();
            n++;
        end while (!prev_acc && n < 20);
        chk("accept_timeout", {31'd0, prev_acc}, 32'd1);
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im,
                        input logic [4:0] r);
        drive(op, f3, f7, a, b, im, r);
        wait_acc();
        in_valid = 1'b0;
    endtask

    task automatic gen();
        int k = $urandom_range(0, 99);
        logic [11:0] i12 = 12'($urandom);
        rs1_data = $urandom;
        rs2_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        imm = {{20{i12[11]}}, i12};
        rd = 5'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'd0;
        if (k < 40) begin
            opcode = 7'b0110011;
            if (funct3 == 3'd0 || funct3 == 3'd5)
                funct7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end else if (k < 75) begin
            opcode = 7'b0010011;
            if (funct3 == 3'd1 || funct3 == 3'd5)
                funct7 = $urandom_range(0, 2) == 0 ? 7'h20 : 7'h00;
            else
                funct7 = 7'($urandom);
        end else if (k < 90) begin
            opcode = 7'b1100011;
            funct3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            funct7 = 7'($urandom);
            if ($urandom_range(0, 1) == 1) rs2_data = rs1_data;
        end else begin
            case ($urandom_range(0, 3))
                0: opcode = 7'b0000011;
                1: opcode = 7'b0100011;
                2: opcode = 7'b1101111;
                default: opcode = 7'b0110111;
            endcase
        end
    endtask

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;
    localparam logic [6:0] B = 7'b1100011;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = 0; funct3 = 0; funct7 = 0;
        rs1_data = 0; rs2_data = 0; imm = 0; rd = 0;
        #12;
        chk("rst_ctrl", {28'd0, alu_control}, 32'h2);
        chk("rst_in1", alu_in1, 32'd0);
        chk("rst_in2", alu_in2, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_taken_ill", {30'd0, out_taken, out_illegal}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // ADD 5 + 7
        send(R, 3'd0, 7'd0, 32'd5, 32'd7, 32'd0, 5'd3);
        chk("add_ctrl", {28'd0, alu_control}, 32'h2);
        step();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result", out_result, 32'd12);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        step();

        // signed SLT both ways
        send(R, 3'd2, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd4);
        chk("slt_in1", alu_in1, 32'h7FFF_FFFF);
        chk("slt_in2", alu_in2, 32'h8000_0001);
        step();
        chk("slt_neg", out_result, 32'd1);
        step();
        send(R, 3'd2, 7'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd4);
        step();
        chk("slt_pos", out_result, 32'd0);
        step();

        // SLLI with an oversized shift amount
        send(I, 3'd1, 7'd0, 32'd1, 32'd0, 32'h21, 5'd5);
        chk("slli_in2", alu_in2, 32'd1);
        step();
        chk("slli_result", out_result, 32'd2);
        step();

        // BEQ / BNE on equal operands
        send(B, 3'd0, 7'd0, 32'd9, 32'd9, 32'd0, 5'd6);
        step();
        chk("beq_taken", {31'd0, out_taken}, 32'd1);
        chk("beq_result", out_result, 32'd0);
        chk("beq_rd", {27'd0, out_rd}, 32'd0);
        step();
        send(B, 3'd1, 7'd0, 32'd9, 32'd9, 32'd0, 5'd6);
        step();
        chk("bne_taken", {31'd0, out_taken}, 32'd0);
        step();

        // illegal opcode
        send(7'b0000011, 3'd2, 7'd0, 32'd3, 32'd4, 32'd8, 5'd7);
        step();
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_result", out_result, 32'd0);
        step();

        // backpressure: four back-to-back ADDs
        out_ready = 1'b0;
        drive(R, 3'd0, 7'd0, 32'd100, 32'd1, 32'd0, 5'd10);
        wait_acc();
        drive(R, 3'd0, 7'd0, 32'd200, 32'd2, 32'd0, 5'd11);
        wait_acc();
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        drive(R, 3'd0, 7'd0, 32'd300, 32'd3, 32'd0, 5'd12);
        step();
        step();
        chk("bp_hold_in1", alu_in1, 32'd200);
        out_ready = 1'b1;
        wait_acc();
        drive(R, 3'd0, 7'd0, 32'd400, 32'd4, 32'd0, 5'd13);
        wait_acc();
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_drained", pend.size(), 32'd0);

        // reset while an entry is waiting
        out_ready = 1'b0;
        send(R, 3'd0, 7'd0, 32'd1, 32'd1, 32'd0, 5'd1);
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        pend.delete();
        prev_acc = 1'b0;
        prev_stall = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ctrl", {28'd0, alu_control}, 32'h2);
        step();
        rst_n = 1'b1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || prev_acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    gen();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        chk("final_drain", pend.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
